// File: rtl/bp_fe_lce_cmd.sv
// ---------------------------------------------------------------------------
// bp_fe_lce_cmd
//
// Front-end LCE command handler for the I-cache. Accepts one CCE-to-LCE
// command at a time, turns tag-updating commands into tag-memory writes,
// answers syncs and invalidates on the LCE response channel, pulses
// tag_set / tag_set_wakeup for the miss-request FSM, and counts completed
// CCE syncs to report when the LCE is ready.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   id_i                    this LCE's id
//   lce_cmd_*               incoming command (valid/yumi handshake)
//   tag_mem_*               tag-memory write request (valid/yumi)
//   tag_set_o               single-cycle pulse when a set_tag write lands
//   tag_set_wakeup_o        single-cycle pulse when a set_tag_wakeup lands
//   lce_ready_o             every CCE has completed its sync
//   lce_resp_*              sync_ack / inv_ack response (valid/yumi)
// ---------------------------------------------------------------------------
module bp_fe_lce_cmd #(
  parameter int num_cce_p             = 1,
  parameter int num_lce_p             = 2,
  parameter int lce_addr_width_p      = 22,
  parameter int lce_sets_p            = 64,
  parameter int ways_p                = 8,
  parameter int block_size_in_bytes_p = 8,
  localparam int lg_num_lce_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int lg_num_cce_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 1,
  localparam int lg_sets_lp    = (lce_sets_p > 1) ? $clog2(lce_sets_p) : 1,
  localparam int lg_ways_lp    = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int lg_blk_lp     = (block_size_in_bytes_p > 1) ? $clog2(block_size_in_bytes_p) : 1,
  localparam int tag_w_lp      = lce_addr_width_p - lg_blk_lp - lg_sets_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [lg_num_lce_lp-1:0]    id_i,

  input  logic                        lce_cmd_v_i,
  output logic                        lce_cmd_yumi_o,
  input  logic [2:0]                  lce_cmd_msg_type_i,
  input  logic [lg_num_cce_lp-1:0]    lce_cmd_src_id_i,
  input  logic [lce_addr_width_p-1:0] lce_cmd_addr_i,
  input  logic [lg_ways_lp-1:0]       lce_cmd_way_id_i,
  input  logic [1:0]                  lce_cmd_state_i,

  output logic                        tag_mem_v_o,
  output logic [lg_sets_lp-1:0]       tag_mem_set_o,
  output logic [ways_p-1:0]           tag_mem_way_mask_o,
  output logic [tag_w_lp-1:0]         tag_mem_tag_o,
  output logic [1:0]                  tag_mem_state_o,
  input  logic                        tag_mem_yumi_i,

  output logic                        tag_set_o,
  output logic                        tag_set_wakeup_o,
  output logic                        lce_ready_o,

  output logic                        lce_resp_v_o,
  output logic [2:0]                  lce_resp_msg_type_o,
  output logic [lg_num_lce_lp-1:0]    lce_resp_src_id_o,
  output logic [lg_num_cce_lp-1:0]    lce_resp_dst_id_o,
  output logic [lce_addr_width_p-1:0] lce_resp_addr_o,
  input  logic                        lce_resp_yumi_i
);

  localparam int cnt_w_lp = ((num_cce_p + 1) > 1) ? $clog2(num_cce_p + 1) : 1;
  localparam logic [cnt_w_lp-1:0] sync_max_lp = cnt_w_lp'(num_cce_p);

  // bp_cce_lce_cmd_type_e
  localparam logic [2:0] e_lce_cmd_sync             = 3'd0;
  localparam logic [2:0] e_lce_cmd_set_clear        = 3'd1;
  localparam logic [2:0] e_lce_cmd_transfer         = 3'd2;
  localparam logic [2:0] e_lce_cmd_writeback        = 3'd3;
  localparam logic [2:0] e_lce_cmd_set_tag          = 3'd4;
  localparam logic [2:0] e_lce_cmd_set_tag_wakeup   = 3'd5;
  localparam logic [2:0] e_lce_cmd_invalidate_tag   = 3'd6;

  // bp_lce_cce_resp_type_e
  localparam logic [2:0] e_lce_cce_sync_ack = 3'd0;
  localparam logic [2:0] e_lce_cce_inv_ack  = 3'd1;

  localparam logic [1:0] e_mesi_i = 2'd0;

  typedef enum logic [1:0] {
    e_ready,
    e_tag_write,
    e_send_resp
  } state_e;

  state_e                       state_q, state_d;
  logic [cnt_w_lp-1:0]          sync_cnt_q, sync_cnt_d;
  logic                         lce_ready_q, lce_ready_d;
  logic [2:0]                   msg_type_q, msg_type_d;
  logic [lg_num_cce_lp-1:0]     src_id_q, src_id_d;
  logic [lce_addr_width_p-1:0]  addr_q, addr_d;
  logic [lg_ways_lp-1:0]        way_id_q, way_id_d;
  logic [1:0]                   cmd_state_q, cmd_state_d;

  // Sync counter stops at num_cce_p so extra syncs never wrap lce_ready low.
  function automatic logic [cnt_w_lp-1:0] sat_inc(input logic [cnt_w_lp-1:0] c);
    return (c == sync_max_lp) ? c : c + cnt_w_lp'(1);
  endfunction

  always_comb begin
    state_d             = state_q;
    sync_cnt_d          = sync_cnt_q;
    msg_type_d          = msg_type_q;
    src_id_d            = src_id_q;
    addr_d              = addr_q;
    way_id_d            = way_id_q;
    cmd_state_d         = cmd_state_q;

    lce_cmd_yumi_o      = 1'b0;
    tag_mem_v_o         = 1'b0;
    tag_mem_set_o       = '0;
    tag_mem_way_mask_o  = '0;
    tag_mem_tag_o       = '0;
    tag_mem_state_o     = '0;
    tag_set_o           = 1'b0;
    tag_set_wakeup_o    = 1'b0;
    lce_resp_v_o        = 1'b0;
    lce_resp_msg_type_o = '0;
    lce_resp_src_id_o   = '0;
    lce_resp_dst_id_o   = '0;
    lce_resp_addr_o     = '0;

    unique case (state_q)
      e_ready: begin
        // Nothing is accepted while reset is held, even if a command is valid.
        lce_cmd_yumi_o = lce_cmd_v_i & ~reset_i;
        if (lce_cmd_yumi_o) begin
          msg_type_d  = lce_cmd_msg_type_i;
          src_id_d    = lce_cmd_src_id_i;
          addr_d      = lce_cmd_addr_i;
          way_id_d    = lce_cmd_way_id_i;
          cmd_state_d = lce_cmd_state_i;
          case (lce_cmd_msg_type_i)
            e_lce_cmd_sync:            state_d = e_send_resp;
            e_lce_cmd_set_clear,
            e_lce_cmd_set_tag,
            e_lce_cmd_set_tag_wakeup,
            e_lce_cmd_invalidate_tag:  state_d = e_tag_write;
            // transfer, writeback and unknown types are consumed and dropped
            default:                   state_d = e_ready;
          endcase
        end
      end

      e_tag_write: begin
        tag_mem_v_o   = 1'b1;
        tag_mem_set_o = addr_q[lg_blk_lp +: lg_sets_lp];
        tag_mem_tag_o = addr_q[lce_addr_width_p-1 : lg_blk_lp+lg_sets_lp];
        if (msg_type_q == e_lce_cmd_set_clear) begin
          tag_mem_way_mask_o = '1;
          tag_mem_state_o    = e_mesi_i;
        end else begin
          tag_mem_way_mask_o = {{(ways_p-1){1'b0}}, 1'b1} << way_id_q;
          tag_mem_state_o    = (msg_type_q == e_lce_cmd_invalidate_tag) ? e_mesi_i : cmd_state_q;
        end
        if (tag_mem_yumi_i) begin
          case (msg_type_q)
            e_lce_cmd_set_tag: begin
              tag_set_o = 1'b1;
              state_d   = e_ready;
            end
            e_lce_cmd_set_tag_wakeup: begin
              tag_set_wakeup_o = 1'b1;
              state_d          = e_ready;
            end
            e_lce_cmd_invalidate_tag: state_d = e_send_resp;
            default:                  state_d = e_ready;
          endcase
        end
      end

      e_send_resp: begin
        lce_resp_v_o        = 1'b1;
        lce_resp_msg_type_o = (msg_type_q == e_lce_cmd_sync) ? e_lce_cce_sync_ack : e_lce_cce_inv_ack;
        lce_resp_src_id_o   = id_i;
        lce_resp_dst_id_o   = src_id_q;
        lce_resp_addr_o     = addr_q;
        if (lce_resp_yumi_i) begin
          if (msg_type_q == e_lce_cmd_sync) begin
            sync_cnt_d = sat_inc(sync_cnt_q);
          end
          state_d = e_ready;
        end
      end

      default: state_d = e_ready;
    endcase

    // Registered from the next count so ready rises with the last sync ack edge.
    lce_ready_d = (sync_cnt_d == sync_max_lp);
  end

  assign lce_ready_o = lce_ready_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      sync_cnt_q  <= '0;
      lce_ready_q <= 1'b0;
      msg_type_q  <= '0;
      src_id_q    <= '0;
      addr_q      <= '0;
      way_id_q    <= '0;
      cmd_state_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      lce_ready_q <= lce_ready_d;
      msg_type_q  <= msg_type_d;
      src_id_q    <= src_id_d;
      addr_q      <= addr_d;
      way_id_q    <= way_id_d;
      cmd_state_q <= cmd_state_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_lce_cmd.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_lce_cmd
//
// Directed bench for bp_fe_lce_cmd with two CCEs. Inputs change and outputs
// are checked 1-2 time units after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_bp_fe_lce_cmd;

  localparam logic [2:0] CMD_SYNC      = 3'd0;
  localparam logic [2:0] CMD_SET_CLEAR = 3'd1;
  localparam logic [2:0] CMD_TRANSFER  = 3'd2;
  localparam logic [2:0] CMD_WRITEBACK = 3'd3;
  localparam logic [2:0] CMD_SET_TAG   = 3'd4;
  localparam logic [2:0] CMD_SET_TAG_W = 3'd5;
  localparam logic [2:0] CMD_INV_TAG   = 3'd6;
  localparam logic [2:0] RESP_SYNC_ACK = 3'd0;
  localparam logic [2:0] RESP_INV_ACK  = 3'd1;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [0:0]  id_i;
  logic        lce_cmd_v_i;
  logic        lce_cmd_yumi_o;
  logic [2:0]  lce_cmd_msg_type_i;
  logic [0:0]  lce_cmd_src_id_i;
  logic [21:0] lce_cmd_addr_i;
  logic [2:0]  lce_cmd_way_id_i;
  logic [1:0]  lce_cmd_state_i;
  logic        tag_mem_v_o;
  logic [5:0]  tag_mem_set_o;
  logic [7:0]  tag_mem_way_mask_o;
  logic [12:0] tag_mem_tag_o;
  logic [1:0]  tag_mem_state_o;
  logic        tag_mem_yumi_i;
  logic        tag_set_o;
  logic        tag_set_wakeup_o;
  logic        lce_ready_o;
  logic        lce_resp_v_o;
  logic [2:0]  lce_resp_msg_type_o;
  logic [0:0]  lce_resp_src_id_o;
  logic [0:0]  lce_resp_dst_id_o;
  logic [21:0] lce_resp_addr_o;
  logic        lce_resp_yumi_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_fe_lce_cmd #(.num_cce_p(2)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .id_i                (id_i),
    .lce_cmd_v_i         (lce_cmd_v_i),
    .lce_cmd_yumi_o      (lce_cmd_yumi_o),
    .lce_cmd_msg_type_i  (lce_cmd_msg_type_i),
    .lce_cmd_src_id_i    (lce_cmd_src_id_i),
    .lce_cmd_addr_i      (lce_cmd_addr_i),
    .lce_cmd_way_id_i    (lce_cmd_way_id_i),
    .lce_cmd_state_i     (lce_cmd_state_i),
    .tag_mem_v_o         (tag_mem_v_o),
    .tag_mem_set_o       (tag_mem_set_o),
    .tag_mem_way_mask_o  (tag_mem_way_mask_o),
    .tag_mem_tag_o       (tag_mem_tag_o),
    .tag_mem_state_o     (tag_mem_state_o),
    .tag_mem_yumi_i      (tag_mem_yumi_i),
    .tag_set_o           (tag_set_o),
    .tag_set_wakeup_o    (tag_set_wakeup_o),
    .lce_ready_o         (lce_ready_o),
    .lce_resp_v_o        (lce_resp_v_o),
    .lce_resp_msg_type_o (lce_resp_msg_type_o),
    .lce_resp_src_id_o   (lce_resp_src_id_o),
    .lce_resp_dst_id_o   (lce_resp_dst_id_o),
    .lce_resp_addr_o     (lce_resp_addr_o),
    .lce_resp_yumi_i     (lce_resp_yumi_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command; it must be taken in the same cycle.
  task automatic send_cmd(input logic [2:0] t, input logic [0:0] src,
                          input logic [21:0] a, input logic [2:0] w, input logic [1:0] s);
    lce_cmd_v_i        = 1'b1;
    lce_cmd_msg_type_i = t;
    lce_cmd_src_id_i   = src;
    lce_cmd_addr_i     = a;
    lce_cmd_way_id_i   = w;
    lce_cmd_state_i    = s;
    #1;
    chk("cmd_yumi", 32'(lce_cmd_yumi_o), 32'd1);
    tick();
    lce_cmd_v_i = 1'b0;
    #1;
  endtask

  // Sync from CCE src with immediate response yumi; checks ack payload and ready afterwards.
  task automatic do_sync(input logic [0:0] src, input logic [21:0] a, input logic exp_ready);
    send_cmd(CMD_SYNC, src, a, 3'd0, 2'd0);
    chk("sync_resp_v",    32'(lce_resp_v_o),        32'd1);
    chk("sync_resp_type", 32'(lce_resp_msg_type_o), 32'(RESP_SYNC_ACK));
    chk("sync_resp_dst",  32'(lce_resp_dst_id_o),   32'(src));
    chk("sync_resp_src",  32'(lce_resp_src_id_o),   32'd1);
    chk("sync_resp_addr", 32'(lce_resp_addr_o),     32'(a));
    lce_resp_yumi_i = 1'b1;
    tick();
    lce_resp_yumi_i = 1'b0;
    #1;
    chk("sync_resp_v_drop", 32'(lce_resp_v_o), 32'd0);
    chk("sync_ready",       32'(lce_ready_o),  32'(exp_ready));
  endtask

  task automatic chk_tag(input string tag, input logic [5:0] set, input logic [7:0] mask,
                         input logic [12:0] tg, input logic [1:0] st);
    chk({tag, "_v"},    32'(tag_mem_v_o),        32'd1);
    chk({tag, "_set"},  32'(tag_mem_set_o),      32'(set));
    chk({tag, "_mask"}, 32'(tag_mem_way_mask_o), 32'(mask));
    chk({tag, "_tag"},  32'(tag_mem_tag_o),      32'(tg));
    chk({tag, "_st"},   32'(tag_mem_state_o),    32'(st));
  endtask

  initial begin
    reset_i = 1'b1; id_i = 1'b1;
    lce_cmd_v_i = 1'b1; lce_cmd_msg_type_i = CMD_SYNC; lce_cmd_src_id_i = '0;
    lce_cmd_addr_i = '0; lce_cmd_way_id_i = '0; lce_cmd_state_i = '0;
    tag_mem_yumi_i = 1'b0; lce_resp_yumi_i = 1'b0;
    tick(); tick();

    // Reset state: nothing accepted even with a valid command pending.
    chk("rst_cmd_yumi",  32'(lce_cmd_yumi_o),   32'd0);
    chk("rst_tag_v",     32'(tag_mem_v_o),      32'd0);
    chk("rst_resp_v",    32'(lce_resp_v_o),     32'd0);
    chk("rst_ready",     32'(lce_ready_o),      32'd0);
    chk("rst_tag_set",   32'(tag_set_o),        32'd0);
    chk("rst_tag_set_w", 32'(tag_set_wakeup_o), 32'd0);
    chk("rst_resp_addr", 32'(lce_resp_addr_o),  32'd0);
    lce_cmd_v_i = 1'b0;
    reset_i = 1'b0;
    tick();

    // Syncs from both CCEs; ready after the second, holds after a third.
    do_sync(1'b0, 22'h000111, 1'b0);
    do_sync(1'b1, 22'h000222, 1'b1);
    do_sync(1'b0, 22'h000333, 1'b1);

    // set_tag with delayed tag write acceptance.
    send_cmd(CMD_SET_TAG, 1'b0, 22'h012345, 3'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      chk_tag("st_wait", 6'h28, 8'h08, 13'h091, 2'd1);
      chk("st_wait_pulse", 32'(tag_set_o), 32'd0);
      tick();
    end
    tag_mem_yumi_i = 1'b1;
    #1;
    chk_tag("st_yumi", 6'h28, 8'h08, 13'h091, 2'd1);
    chk("st_pulse",   32'(tag_set_o),        32'd1);
    chk("st_pulse_w", 32'(tag_set_wakeup_o), 32'd0);
    tick();
    tag_mem_yumi_i = 1'b0;
    #1;
    chk("st_done_v",     32'(tag_mem_v_o),  32'd0);
    chk("st_done_pulse", 32'(tag_set_o),    32'd0);
    chk("st_done_resp",  32'(lce_resp_v_o), 32'd0);

    // set_tag_wakeup with immediate acceptance.
    send_cmd(CMD_SET_TAG_W, 1'b1, 22'h000208, 3'd7, 2'd2);
    tag_mem_yumi_i = 1'b1;
    #1;
    chk_tag("stw", 6'h01, 8'h80, 13'h001, 2'd2);
    chk("stw_pulse_w", 32'(tag_set_wakeup_o), 32'd1);
    chk("stw_pulse",   32'(tag_set_o),        32'd0);
    tick();
    tag_mem_yumi_i = 1'b0;
    #1;
    chk("stw_done_pulse_w", 32'(tag_set_wakeup_o), 32'd0);

    // set_clear of set 5: all ways, state I, no response.
    send_cmd(CMD_SET_CLEAR, 1'b0, 22'h000028, 3'd2, 2'd3);
    tag_mem_yumi_i = 1'b1;
    #1;
    chk_tag("clr", 6'h05, 8'hFF, 13'h000, 2'd0);
    chk("clr_pulse", 32'(tag_set_o | tag_set_wakeup_o), 32'd0);
    tick();
    tag_mem_yumi_i = 1'b0;
    #1;
    chk("clr_resp_v", 32'(lce_resp_v_o), 32'd0);
    chk("clr_tag_v",  32'(tag_mem_v_o),  32'd0);

    // invalidate_tag; a new command waits behind it.
    send_cmd(CMD_INV_TAG, 1'b1, 22'h03ABCD, 3'd1, 2'd1);
    lce_cmd_v_i = 1'b1; lce_cmd_msg_type_i = CMD_TRANSFER;
    lce_cmd_addr_i = 22'h000040;
    tag_mem_yumi_i = 1'b1;
    #1;
    chk_tag("inv", 6'h39, 8'h02, 13'h1D5, 2'd0);
    chk("inv_busy_yumi_tw", 32'(lce_cmd_yumi_o), 32'd0);
    tick();
    tag_mem_yumi_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("inv_resp_v",    32'(lce_resp_v_o),        32'd1);
      chk("inv_resp_type", 32'(lce_resp_msg_type_o), 32'(RESP_INV_ACK));
      chk("inv_resp_dst",  32'(lce_resp_dst_id_o),   32'd1);
      chk("inv_resp_addr", 32'(lce_resp_addr_o),     32'h03ABCD);
      chk("inv_busy_yumi", 32'(lce_cmd_yumi_o),      32'd0);
      tick();
    end
    lce_resp_yumi_i = 1'b1;
    #1;
    chk("inv_ack_yumi_cycle_cmd", 32'(lce_cmd_yumi_o), 32'd0);
    tick();
    lce_resp_yumi_i = 1'b0;
    #1;
    chk("inv_done_resp_v",  32'(lce_resp_v_o),   32'd0);
    chk("waiting_cmd_yumi", 32'(lce_cmd_yumi_o), 32'd1);
    tick();
    lce_cmd_v_i = 1'b0;
    #1;

    // The transfer was dropped: no tag write, no response, back in ready.
    chk("xfer_tag_v",  32'(tag_mem_v_o),  32'd0);
    chk("xfer_resp_v", 32'(lce_resp_v_o), 32'd0);
    tick();
    chk("xfer_idle_tag_v", 32'(tag_mem_v_o), 32'd0);
    send_cmd(CMD_WRITEBACK, 1'b0, 22'h000080, 3'd0, 2'd0);
    chk("wb_tag_v",  32'(tag_mem_v_o),  32'd0);
    chk("wb_resp_v", 32'(lce_resp_v_o), 32'd0);
    send_cmd(CMD_TRANSFER, 1'b1, 22'h0000C0, 3'd0, 2'd0);
    chk("xfer2_resp_v", 32'(lce_resp_v_o), 32'd0);

    // Reset while a sync ack is pending.
    send_cmd(CMD_SYNC, 1'b1, 22'h000444, 3'd0, 2'd0);
    chk("rs_resp_v",  32'(lce_resp_v_o), 32'd1);
    chk("rs_ready_before", 32'(lce_ready_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    chk("rs_resp_v_drop", 32'(lce_resp_v_o), 32'd0);
    chk("rs_ready_clear", 32'(lce_ready_o),  32'd0);
    lce_resp_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_no_late_ack",   32'(lce_resp_v_o), 32'd0);
      chk("rs_ready_stays_0", 32'(lce_ready_o),  32'd0);
    end
    lce_resp_yumi_i = 1'b0;
    #1;

    // Counter restarted at 0: one sync is not enough for ready.
    do_sync(1'b0, 22'h000555, 1'b0);
    do_sync(1'b1, 22'h000666, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_lce_cmd.md
Name: bp_fe_lce_cmd

Overview:
- Front-end LCE command handler for the I-cache.
- Consumes CCE-to-LCE commands, applies tag-memory writes, and returns sync/invalidate acks on a dedicated LCE response channel.
- Raises the tag_set / tag_set_wakeup pulses consumed by the downstream LCE miss-request FSM.
- Tracks CCE sync completion and reports LCE readiness to the cache.

Parameters:
- num_cce_p, 1, number of CCEs; also the number of syncs needed for ready.
- num_lce_p, 2, number of LCEs; id width = BSG_SAFE_CLOG2(num_lce_p).
- lce_addr_width_p, 22, physical block address width.
- lce_sets_p, 64, cache sets; lg_sets = BSG_SAFE_CLOG2(lce_sets_p).
- ways_p, 8, associativity; lg_ways = BSG_SAFE_CLOG2(ways_p).
- block_size_in_bytes_p, 8, offset bits lg_blk = BSG_SAFE_CLOG2(block_size_in_bytes_p).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- id_i  in  lg_num_lce  this LCE's id
- lce_cmd_v_i  in  1  command valid
- lce_cmd_yumi_o  out  1  command consumed this cycle
- lce_cmd_msg_type_i  in  3  bp_cce_lce_cmd_type_e
- lce_cmd_src_id_i  in  lg_num_cce  issuing CCE
- lce_cmd_addr_i  in  lce_addr_width_p  block address
- lce_cmd_way_id_i  in  lg_ways  target way
- lce_cmd_state_i  in  2  coherence state to write
- tag_mem_v_o  out  1  tag write request
- tag_mem_set_o  out  lg_sets  set index
- tag_mem_way_mask_o  out  ways_p  one-hot way, or all-ones for set_clear
- tag_mem_tag_o  out  lce_addr_width_p-lg_blk-lg_sets  tag
- tag_mem_state_o  out  2  state written (e_MESI_I for clears/invalidates)
- tag_mem_yumi_i  in  1  tag write accepted
- tag_set_o  out  1  pulse: set_tag completed
- tag_set_wakeup_o  out  1  pulse: set_tag_wakeup completed
- lce_ready_o  out  1  all CCE syncs done
- lce_resp_v_o  out  1  response valid
- lce_resp_msg_type_o  out  3  e_lce_cce_sync_ack or e_lce_cce_inv_ack
- lce_resp_src_id_o  out  lg_num_lce  = id_i
- lce_resp_dst_id_o  out  lg_num_cce  latched cmd src_id
- lce_resp_addr_o  out  lce_addr_width_p  latched cmd addr
- lce_resp_yumi_i  in  1  response consumed

Behaviour:
- Address split:
  - set = addr[lg_blk +: lg_sets]
  - tag = addr[lce_addr_width_p-1 : lg_blk+lg_sets]
- FSM states: e_ready, e_tag_write, e_send_resp.
- e_ready:
  - lce_cmd_yumi_o = lce_cmd_v_i, combinational.
  - On yumi, latch msg_type, src_id, addr, way_id, state.
  - Dispatch on the latched type:
    - e_lce_cmd_sync -> e_send_resp
    - set_clear, set_tag, set_tag_wakeup, invalidate_tag -> e_tag_write
    - transfer, writeback, or any other type -> consumed and dropped; stay in e_ready.
- e_tag_write:
  - tag_mem_v_o = 1; hold all tag_mem outputs stable until tag_mem_yumi_i.
  - Outputs by command:
    - set_clear: way_mask all-ones, state I.
    - invalidate_tag: one-hot way, state I.
    - set_tag / set_tag_wakeup: one-hot way, latched tag and state.
  - On yumi:
    - set_tag -> tag_set_o = 1 that same cycle, then e_ready.
    - set_tag_wakeup -> tag_set_wakeup_o = 1 that same cycle, then e_ready.
    - set_clear -> e_ready, no response.
    - invalidate_tag -> e_send_resp.
- e_send_resp:
  - lce_resp_v_o = 1; msg_type sync_ack for sync, inv_ack for invalidate.
  - Payload held stable until lce_resp_yumi_i; on yumi -> e_ready.
  - A sync_ack yumi increments sync_cnt (width BSG_SAFE_CLOG2(num_cce_p+1)); sync_cnt saturates at num_cce_p.
- lce_ready_o = (sync_cnt == num_cce_p); registered and monotonic until reset.
- At most one command in flight. No new command is consumed outside e_ready, so lce_cmd_yumi_o = 0 while busy even if lce_cmd_v_i = 1.
- Best-case latencies:
  - set_tag: 1 cycle accept + 1 cycle write (pulse in cycle 2).
  - sync: ack valid the cycle after accept.
- Reset:
  - state e_ready, sync_cnt 0, all latched fields 0.
  - All outputs 0: yumi, tag_mem_v, pulses, lce_ready, resp_v, data fields.
  - Reset mid-operation abandons the command; no pulse or response is emitted afterwards.
- tag_set_o and tag_set_wakeup_o are single-cycle and never both high.

Test Plan:
- Reset, num_cce_p=2; two syncs from CCE 0 and 1, resp yumi immediate -> two sync_acks with dst 0 then 1; lce_ready_o=0 after first, 1 after second; a third sync keeps sync_cnt at 2.
- set_tag addr=0x12345, way 3, state S, tag_mem_yumi_i delayed 3 cycles -> set=addr[3+:6], way_mask=8'b0000_1000, outputs stable; tag_set_o high exactly in the yumi cycle.
- set_tag_wakeup -> only tag_set_wakeup_o pulses. set_clear set 5 -> way_mask=8'hFF, state I, no lce_resp_v_o.
- invalidate_tag with lce_resp_yumi_i held low 4 cycles -> tag write, then inv_ack valid with stable addr/dst; a new cmd presented meanwhile is not yumi'd until after the ack.
- transfer command -> yumi in 1 cycle, no tag write, no response, FSM stays e_ready.
- Assert reset_i during e_send_resp (sync) -> resp_v drops next cycle, sync_cnt=0, lce_ready_o=0, no late ack.
